// File: rtl/flash_read_seq_pkg.sv
// flash_read_seq_pkg: sequencer state encoding and SPI-flash opcodes shared by the read path.
package flash_read_seq_pkg;
  typedef enum logic [2:0] {IDLE, CMD, A2, A1, A0, DATA, FIN} state_t;
  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic [7:0] FLASH_CMD_JEDEC_ID = 8'h9F;
endpackage

// File: rtl/flash_read_seq_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO with an occupancy count one bit wider than the pointers.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/flash_read_seq.sv
// flash_read_seq: turns one read request into an SPI-flash READ (cmd, 3 address bytes, N data bytes)
// and buffers the received data bytes as a valid/ready stream.
module flash_read_seq
  import flash_read_seq_pkg::*;
#(
  parameter int         LEN_W      = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] READ_CMD   = FLASH_CMD_READ,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             spi_select,
  output logic             spi_write,
  output logic [7:0]       spi_tx,
  input  logic             spi_busy,
  input  logic             spi_avail,
  input  logic [7:0]       spi_rx,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, next_state;
  logic waiting;
  logic [23:0] addr_q;
  logic [LEN_W-1:0] remaining;
  logic [7:0] tx_byte;
  logic can_issue, push, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  always_comb begin
    tx_byte = (state == CMD) ? READ_CMD :
              (state == A2) ? addr_q[23:16] :
              (state == A1) ? addr_q[15:8] :
              (state == A0) ? addr_q[7:0] : DUMMY_BYTE;
    next_state = (state == CMD) ? A2 :
                 (state == A2) ? A1 :
                 (state == A1) ? A0 :
                 (state == A0) ? DATA :
                 (state == DATA) ? ((remaining == LEN_W'(1)) ? FIN : DATA) : IDLE;
  end
  // a data byte is only launched when its reply is guaranteed a FIFO slot
  assign can_issue = !spi_busy && (state != DATA || fifo_count < CW'(FIFO_DEPTH));
  assign push = state == DATA && waiting && spi_avail && !fifo_full;
  assign out_valid = !fifo_empty;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .din(spi_rx),
    .pop(out_valid && out_ready),
    .dout(out_data),
    .empty(fifo_empty),
    .full(fifo_full),
    .count(fifo_count)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      waiting <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      spi_select <= 1'b0;
      spi_write <= 1'b0;
      spi_tx <= '0;
      addr_q <= '0;
      remaining <= '0;
    end else begin
      spi_write <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr_q <= addr;
          remaining <= len;
          busy <= 1'b1;
          spi_select <= 1'b1;
          state <= (len == '0) ? FIN : CMD;
          // launch the command byte straight away so it goes out the cycle after start
          waiting <= len != '0 && !spi_busy;
          spi_write <= len != '0 && !spi_busy;
          spi_tx <= READ_CMD;
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          spi_select <= 1'b0;
          state <= IDLE;
        end
        default: if (!waiting) begin
          if (can_issue) begin
            spi_write <= 1'b1;
            spi_tx <= tx_byte;
            waiting <= 1'b1;
          end
        end else if (spi_avail) begin
          waiting <= 1'b0;
          if (state == DATA) remaining <= remaining - LEN_W'(1);
          state <= next_state;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_read_seq.sv
// tb_flash_read_seq: directed tests with a transaction-level scoreboard checked every cycle,
// plus literal expectations and a direct check of the FIFO boundary cases.
module tb_flash_read_seq;
  logic clk = 1'b0;
  logic resetn, start, spi_busy, spi_avail, out_ready;
  logic [23:0] addr;
  logic [15:0] len;
  logic [7:0] spi_rx, spi_tx, out_data;
  logic busy, done, spi_select, spi_write, out_valid;
  logic f_push, f_pop, f_empty, f_full;
  logic [7:0] f_din, f_dout;
  logic [2:0] f_count;
  int checks = 0, errors = 0, cyc = 0;
  byte unsigned exp_tx[$], exp_out[$], tx_log[$], out_log[$];
  int occ = 0, max_occ = 0, done_cnt = 0, done_cyc = 0, wr_cnt = 0, first_wr_cyc = 0;
  int last_avail_cyc = 0, busy_cyc = 0, start_cyc = 0, spi_idx = 0, timer = 0;
  bit outstanding = 0, data_avail = 0;

  flash_read_seq #(.LEN_W(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .spi_select(spi_select), .spi_write(spi_write), .spi_tx(spi_tx),
    .spi_busy(spi_busy), .spi_avail(spi_avail), .spi_rx(spi_rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );
  byte_fifo #(.DEPTH(4)) u_fifo (
    .clk(clk), .resetn(resetn), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .empty(f_empty), .full(f_full), .count(f_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // SPI engine: 8-cycle byte time, replies A0 + byte index within the transaction
  initial begin
    spi_busy = 0; spi_avail = 0; spi_rx = 0;
    forever begin
      @(posedge clk); #2;
      spi_avail = 0; data_avail = 0;
      if (!resetn) begin
        timer = 0; spi_busy = 0; spi_idx = 0;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          spi_busy = 0; spi_avail = 1; spi_rx = 8'hA0 + 8'(spi_idx);
          data_avail = spi_idx >= 4; spi_idx++;
        end
      end else if (spi_write) begin
        spi_busy = 1; timer = 8;
      end
      if (!spi_select && !spi_write) spi_idx = 0;
    end
  end

  // scoreboard: transmitted bytes, delivered bytes and FIFO occupancy, checked every cycle
  always @(negedge clk) if (resetn) begin
    chk("select_vs_busy", spi_select, busy);
    chk("out_valid_vs_occupancy", out_valid, occ != 0);
    if (spi_write) begin
      chk("one_outstanding", outstanding, 0);
      if (exp_tx.size() == 0) chk("unexpected_spi_write", 1, 0);
      else chk("spi_tx", spi_tx, exp_tx.pop_front());
      tx_log.push_back(spi_tx); wr_cnt++; outstanding = 1;
      if (wr_cnt == 1) first_wr_cyc = cyc;
    end
    if (spi_avail) begin
      outstanding = 0;
      if (data_avail) last_avail_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) chk("unexpected_out_byte", 1, 0);
      else chk("out_data", out_data, exp_out.pop_front());
      out_log.push_back(out_data);
    end
    occ += int'(data_avail) - int'(out_valid && out_ready);
    if (occ > max_occ) max_occ = occ;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cyc++;
  end

  task automatic expect_txn(logic [23:0] a, int n);
    exp_tx.push_back(8'h03);
    exp_tx.push_back(a[23:16]); exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(8'h00);
      exp_out.push_back(8'(8'hA4 + k));
    end
  endtask

  task automatic go(logic [23:0] a, logic [15:0] n);
    addr = a; len = n; start = 1; start_cyc = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(int base, int limit);
    int t = 0;
    while (done_cnt == base && t < limit) begin tick(); t++; end
    if (done_cnt == base) chk("done_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    tx_log.delete(); out_log.delete(); wr_cnt = 0; max_occ = occ;
  endtask

  initial begin
    byte unsigned t1[8] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    byte unsigned o1[4] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7};
    byte unsigned t5[6] = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00};
    int base, b0, w0, t;
    resetn = 0; start = 0; addr = 0; len = 0; out_ready = 1;
    f_push = 0; f_pop = 0; f_din = 0;
    tick(3);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_select", spi_select, 0);
    chk("rst_write", spi_write, 0); chk("rst_tx", spi_tx, 0); chk("rst_out_valid", out_valid, 0);
    resetn = 1;
    tick();

    // FIFO boundaries: push+pop on empty, on one entry, and on full
    f_push = 1; f_pop = 1; f_din = 8'h11; tick();
    chk("fifo_empty_pushpop_count", f_count, 1); chk("fifo_empty_pushpop_dout", f_dout, 8'h11);
    f_din = 8'h22; tick();
    chk("fifo_one_pushpop_count", f_count, 1); chk("fifo_one_pushpop_dout", f_dout, 8'h22);
    f_pop = 0;
    f_din = 8'h33; tick(); f_din = 8'h44; tick(); f_din = 8'h55; tick();
    chk("fifo_full_flag", f_full, 1); chk("fifo_full_count", f_count, 4);
    f_pop = 1; f_din = 8'h66; tick();
    chk("fifo_full_pushpop_count", f_count, 4); chk("fifo_full_pushpop_dout", f_dout, 8'h33);
    f_push = 0; tick(4); f_pop = 0;
    chk("fifo_drained_empty", f_empty, 1); chk("fifo_drained_count", f_count, 0);

    // basic 4-byte read
    clear_logs(); base = done_cnt;
    expect_txn(24'h123456, 4);
    go(24'h123456, 4);
    wait_done(base, 500); tick(3);
    chk("first_write_latency", first_wr_cyc - start_cyc, 1);
    chk("t1_write_count", wr_cnt, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_tx%0d", i), tx_log[i], t1[i]);
    chk("t1_out_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_out%0d", i), out_log[i], o1[i]);
    chk("t1_done_pulses", done_cnt - base, 1);
    chk("t1_done_after_last_avail", done_cyc - last_avail_cyc, 2);

    // zero-length request
    clear_logs(); base = done_cnt; b0 = busy_cyc;
    go(24'h000010, 0);
    wait_done(base, 50); tick(2);
    chk("len0_done_cycle", done_cyc - start_cyc, 2);
    chk("len0_busy_cycles", busy_cyc - b0, 1);
    chk("len0_no_write", wr_cnt, 0);

    // back-pressure: consumer stalled, SPI traffic stops after 16 data bytes
    clear_logs(); base = done_cnt; out_ready = 0;
    expect_txn(24'h0A0B0C, 40);
    go(24'h0A0B0C, 40);
    tick(2000);
    chk("stall_writes", wr_cnt, 20);
    chk("stall_select", spi_select, 1);
    chk("stall_occupancy", max_occ, 16);
    out_ready = 1;
    wait_done(base, 2000); tick(3);
    chk("stall_out_count", out_log.size(), 40);
    chk("stall_last_byte", out_log[39], 8'hCB);
    chk("stall_max_occupancy", max_occ, 16);

    // start while busy is ignored
    clear_logs(); base = done_cnt;
    expect_txn(24'hABCDEF, 2);
    go(24'hABCDEF, 2);
    tick(15);
    go(24'h111111, 5);
    wait_done(base, 500); tick(20);
    chk("ignored_write_count", wr_cnt, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("ignored_tx%0d", i), tx_log[i], t5[i]);
    chk("ignored_done_pulses", done_cnt - base, 1);
    chk("ignored_idle", busy, 0);

    // reset while the A1 byte is in flight
    clear_logs(); base = done_cnt; w0 = wr_cnt;
    expect_txn(24'h123456, 3);
    go(24'h123456, 3);
    t = 0;
    while (wr_cnt < w0 + 3 && t < 200) begin tick(); t++; end
    chk("reach_a1", tx_log[2], 8'h34);
    resetn = 0;
    exp_tx.delete(); exp_out.delete(); occ = 0; outstanding = 0;
    tick();
    resetn = 1;
    chk("abort_select", spi_select, 0); chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0); chk("abort_done", done, 0);
    tick(20);
    chk("abort_no_done", done_cnt - base, 0);
    clear_logs();
    expect_txn(24'h00FF01, 2);
    go(24'h00FF01, 2);
    wait_done(base, 500); tick(3);
    chk("after_abort_writes", wr_cnt, 6);
    chk("after_abort_addr_mid", tx_log[2], 8'hFF);
    chk("after_abort_outs", out_log.size(), 2);

    // consumer toggling ready every cycle
    clear_logs(); base = done_cnt; out_ready = 0;
    expect_txn(24'h000100, 20);
    go(24'h000100, 20);
    t = 0;
    while (done_cnt == base && t < 2000) begin out_ready = ~out_ready; tick(); t++; end
    if (done_cnt == base) chk("toggle_done_timeout", 0, 1);
    out_ready = 1; tick(5);
    chk("toggle_out_count", out_log.size(), 20);
    chk("toggle_first", out_log[0], 8'hA4);
    chk("toggle_last", out_log[19], 8'hB7);
    chk("toggle_exp_empty", exp_out.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
